// File: rtl/rvr32_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rvr32_lsu
// Purpose  : Load/store initiator for the Rover32 native memory bus. Accepts
//            one core request at a time, issues a single word-aligned bus
//            transaction with byte strobes and lane-replicated write data,
//            then returns sign/zero-extended load data or an error.
// Ports    : clk, resetn (sync, active-low)
//            req_*  : core request (valid/ready, we, size, signed, addr, wdata)
//            rsp_*  : one-cycle completion pulse with rdata and err
//            mem_*  : memory bus (valid/addr/wdata/wstrb out, rdata/ready in)
// Params   : TIMEOUT - BUS cycles to wait for mem_ready; 0 disables.
// Macro    : RVR32_LSU_MISALIGN_TRAP_EN - misaligned half/word accesses
//            return an error instead of being force-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module rvr32_lsu #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam bit            TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic          req_ready_q;
  logic          mem_valid_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wstrb_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;

  // Decode of the incoming request: effective byte offset after any
  // force-alignment, strobes, replicated data and up-front error.
  logic          acc_err;
  logic [1:0]    acc_off;
  logic [3:0]    acc_strb;
  logic [31:0]   acc_wdata;

  always_comb begin
    acc_err   = 1'b0;
    acc_off   = req_addr[1:0];
    acc_strb  = 4'b0000;
    acc_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        acc_strb  = 4'b0001 << req_addr[1:0];
        acc_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        acc_off   = {req_addr[1], 1'b0};
        acc_strb  = 4'b0011 << {req_addr[1], 1'b0};
        acc_wdata = {2{req_wdata[15:0]}};
`ifdef RVR32_LSU_MISALIGN_TRAP_EN
        acc_err   = req_addr[0];
`endif
      end
      2'b10: begin
        acc_off   = 2'b00;
        acc_strb  = 4'b1111;
`ifdef RVR32_LSU_MISALIGN_TRAP_EN
        acc_err   = (req_addr[1:0] != 2'b00);
`endif
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Returned-word lane extraction and extension.
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{signed_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            size_q      <= req_size;
            signed_q    <= req_signed;
            off_q       <= acc_off;
            cnt_q       <= '0;
            if (acc_err) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= S_BUS;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= acc_wdata;
              mem_wstrb_q <= req_we ? acc_strb : 4'b0000;
            end
          end
        end
        S_BUS: begin
          // A ready arriving in the expiry cycle takes priority.
          if (mem_ready) begin
            state_q     <= S_RESP;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'h0 : load_data;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_q     <= S_RESP;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rvr32_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvr32_lsu
// Purpose  : Scoreboard bench for rvr32_lsu (TIMEOUT=8). A driver issues
//            directed and random requests and pushes expected bus and
//            response records computed from an arithmetic model; a memory
//            responder answers with planned latency/data; a monitor pops and
//            compares whenever the DUT presents a bus request or response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvr32_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  rvr32_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          we;
    int          cyc;
  } bus_exp_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_exp_t;

  bus_exp_t    bus_q[$];
  rsp_exp_t    rsp_q[$];
  int          plan_n[$];
  logic [31:0] plan_rd[$];

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  bit rst_at_edge = 1'b1;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
`ifdef RVR32_LSU_MISALIGN_TRAP_EN
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Byte offset within the word, rounded down to the access size.
  function automatic int m_off(input int nb, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    return a - (a % nb);
  endfunction

  function automatic logic [3:0] m_strb(input int nb, input int off);
    int s;
    s = ((1 << nb) - 1) << off;
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int nb);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int nb,
                                         input int off, input bit sgn);
    longint unsigned full, v;
    full = 64'd1 << (8 * nb);
    v = ({32'h0, rd} >> (8 * off)) % full;
    if (sgn && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  // ---------------- cycle counter / reset sampling ----------------
  initial forever begin
    @(posedge clk);
    rst_at_edge = !resetn;
    cyc_cnt++;
  end

  // ---------------- memory responder ----------------
  initial begin
    int cnt, n;
    logic [31:0] rd;
    cnt = 0; n = 0; rd = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (cnt == 0) begin
          if (plan_n.size() > 0) begin
            n  = plan_n.pop_front();
            rd = plan_rd.pop_front();
          end else begin
            n = 1000;
          end
        end
        cnt++;
        mem_ready = (cnt == n);
        mem_rdata = (cnt == n) ? rd : $urandom;
      end else begin
        // Noise outside BUS must be ignored by the DUT.
        cnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bus_exp_t    b, cur;
    rsp_exp_t    r;
    logic [31:0] last_rdata;
    bit          prev_mv;
    last_rdata = '0;
    prev_mv = 1'b0;
    cur = '{addr: '0, strb: '0, wdata: '0, we: 1'b0, cyc: 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst_at_edge) begin
          last_rdata = '0;
          prev_mv = 1'b0;
        end else begin
          if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
              chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
              r = rsp_q.pop_front();
              chk("rsp_err", 32'(rsp_err), 32'(r.err));
              chk("rsp_rdata", rsp_rdata, r.rdata);
              chk("rsp_cycle", 32'(cyc_cnt), 32'(r.cyc));
              chk("rsp_mem_valid_low", 32'(mem_valid), 32'h0);
              chk("rsp_req_ready_low", 32'(req_ready), 32'h0);
              last_rdata = r.rdata;
            end
          end else begin
            chk("rsp_rdata_hold", rsp_rdata, last_rdata);
          end
          if (mem_valid && !prev_mv) begin
            if (bus_q.size() == 0) begin
              chk("unexpected_mem_valid", 32'(mem_valid), 32'h0);
            end else begin
              b = bus_q.pop_front();
              cur = b;
              chk("mem_addr", mem_addr, b.addr);
              chk("mem_wstrb", 32'(mem_wstrb), 32'(b.strb));
              if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
              chk("mem_valid_cycle", 32'(cyc_cnt), 32'(b.cyc));
            end
          end else if (mem_valid) begin
            chk("mem_addr_stable", mem_addr, cur.addr);
            chk("mem_wstrb_stable", 32'(mem_wstrb), 32'(cur.strb));
          end
          prev_mv = mem_valid;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left on a negedge. n = mem_valid cycle in which ready comes.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int n, input logic [31:0] rd, input bit expect_rsp);
    int       waited;
    bit       perr;
    int       nb, off;
    bus_exp_t b;
    rsp_exp_t r;
    waited = 0;
    while (!req_ready) begin
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL req_ready_wait: got 0 expected 1 within 200 cycles");
        req_valid = 1'b0;
        return;
      end
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      waited++;
      @(negedge clk);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    perr = m_err(size, addr);
    nb   = 1 << size;
    off  = m_off(nb, addr);
    if (!perr) begin
      b.addr  = addr & 32'hFFFF_FFFC;
      b.strb  = we ? m_strb(nb, off) : 4'b0000;
      b.wdata = m_wdata(wdata, nb);
      b.we    = we;
      b.cyc   = cyc_cnt + 1;
      bus_q.push_back(b);
      plan_n.push_back(n);
      plan_rd.push_back(rd);
    end
    r.err   = perr || (n > TMO);
    r.rdata = (r.err || we) ? 32'h0 : m_load(rd, nb, off, sgn);
    r.cyc   = cyc_cnt + (perr ? 1 : (((n < TMO) ? n : TMO) + 1));
    if (expect_rsp) rsp_q.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int drain;
    resetn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    do_req(1, 2'd2, 0, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'h0, 1);
    do_req(1, 2'd0, 0, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0, 1);
    do_req(0, 2'd1, 1, 32'h0000_0302, 32'h0, 2, 32'h8001_1234, 1);
    do_req(0, 2'd0, 0, 32'h0000_0301, 32'h0, 1, 32'h8001_1234, 1);
    do_req(0, 2'd2, 0, 32'h0000_0401, 32'h0, 1, 32'hCAFE_F00D, 1);
    do_req(1, 2'd1, 0, 32'h0000_0603, 32'h0000_BEEF, 2, 32'h0, 1);
    do_req(0, 2'd2, 0, 32'h0000_0500, 32'h0, 1000, 32'h0, 1);
    do_req(0, 2'd2, 0, 32'h0000_0504, 32'h0, TMO, 32'h1234_5678, 1);
    do_req(1, 2'd3, 0, 32'h0000_0700, 32'h1111_1111, 1, 32'h0, 1);

    // Reset while the bus transaction is outstanding.
    do_req(0, 2'd2, 0, 32'h0000_0800, 32'h0, 1000, 32'h0, 0);
    @(negedge clk);
    chk("mid_reset_mem_valid_before", 32'(mem_valid), 32'h1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("mid_reset_req_ready", 32'(req_ready), 32'h1);
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    resetn = 1'b1;
    plan_n.delete();
    plan_rd.delete();

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      logic [1:0] sz;
      int         n;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n  = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom, n, $urandom, 1);
    end

    drain = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && drain < 300) begin
      @(negedge clk);
      drain++;
    end
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d rsp / %0d bus pending expected 0", rsp_q.size(), bus_q.size());
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rvr32_lsu.md
# rvr32_lsu

Load/store initiator for the Rover32 native memory bus. It accepts one load or store request from the core pipeline and drives the valid/addr/wdata/wstrb/rdata/ready handshake toward the memory controller. It generates byte strobes and lane-replicated write data, then extracts and sign- or zero-extends the returned load data. It sits between the execute stage and the memory controller, and has at most one transaction outstanding.

## Interface
- `TIMEOUT`, default 0: cycles to wait for `mem_ready` before aborting with error. 0 disables the timeout.
- `clk` in 1: single clock; all state changes on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: core request strobe.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data. Zero for stores and errors. Held until the next `rsp_valid`.
- `rsp_err` out 1: qualifies `rsp_valid`; misaligned, reserved size, or timeout.
- `mem_valid` out 1: bus request.
- `mem_addr` out 32: word address, bits [1:0] always 00.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte strobes; 0000 for loads.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.
- `mem_ready` in 1: transaction complete.

## Operation
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- **Reset values:** state IDLE; `mem_valid`, `rsp_valid`, and `rsp_err` are 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, and `rsp_rdata` are 0; `req_ready` is 1.
- **IDLE, on accept:** capture the request.
  - If it has an error → RESP with `rsp_err=1`, and no bus transaction is issued.
  - Otherwise → BUS, with `mem_valid`, `mem_addr`, `mem_wdata`, and `mem_wstrb` loaded.
- **Strobes:**
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
- **Write data:**
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- **BUS:** all `mem_*` outputs are held stable.
  - On `mem_ready`: load data is `mem_rdata >> (8*addr[1:0])`, truncated to the size and then extended. `mem_valid` goes to 0 and the FSM → RESP.
  - `mem_ready` is ignored in every state except BUS.
- **Timeout** (`TIMEOUT` ≠ 0): a counter runs in BUS. If `TIMEOUT` cycles elapse with no `mem_ready`, `mem_valid` drops and the FSM → RESP with `rsp_err=1`. If `mem_ready` arrives in the same cycle the count expires, it wins and the response is not an error.
- **RESP:** `rsp_valid=1` for exactly one cycle, then → IDLE.
- **Reserved size:** `req_size=11` is always an error.
- **Reset mid-transaction:** forces IDLE in the next cycle and drops `mem_valid`. No `rsp_valid` is issued for the aborted request.

## Timing
- A request accepted at edge 0 produces `mem_valid=1` in cycle 1.
- `mem_ready` sampled in cycle k gives `mem_valid=0` and `rsp_valid=1` in cycle k+1.
- Minimum total latency is 2 cycles.
- `req_ready` is high again in cycle k+2, so back-to-back requests have `mem_valid` low for at least 2 cycles. The controller sees a falling edge between transactions, which its state clear depends on.
- An error response without a bus transaction arrives 1 cycle after accept.

## Configuration
- **`RVR32_LSU_MISALIGN_TRAP_EN` defined:** a half access with addr[0]=1, or a word access with addr[1:0]≠00, completes as `rsp_err=1` with no bus access.
- **Not defined:** misaligned addresses are force-aligned down (half clears bit 0; word clears bits [1:0]) and executed normally, with no error.

## Test plan
- Word store, addr 0x100, wdata 0xDEADBEEF, ready after 3 cycles → `mem_addr=0x100`, `mem_wstrb=1111`, `mem_wdata=0xDEADBEEF`; `rsp_valid` 1 cycle after ready, `rsp_err=0`.
- Byte store, addr 0x203, wdata 0x000000A5 → `mem_addr=0x200`, `mem_wstrb=1000`, `mem_wdata=0xA5A5A5A5`.
- Signed half load, addr 0x302, `mem_rdata=0x8001_1234` → `rsp_rdata=0xFFFF8001`. Unsigned byte load, addr 0x301, same rdata → `rsp_rdata=0x00000012`.
- Word load, addr 0x401:
  - with the macro: `rsp_err=1` one cycle after accept, `mem_valid` never asserted;
  - without the macro: `mem_addr=0x400` and a normal response.
- `TIMEOUT=8`, `mem_ready` held low → `mem_valid` drops after 8 cycles, then `rsp_valid=1` with `rsp_err=1`. Repeat with ready arriving in cycle 8 → `rsp_err=0`.
- `resetn` low during BUS → next cycle `mem_valid=0`, `req_ready=1`, no `rsp_valid`.
